// File: rtl/seg7_display_controller.sv
// Multi-digit seven-segment controller: hex or decimal (double-dabble) display with
// leading-zero blanking, overflow dashes and whole-display blink.
module seg7_display_controller #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned VALUE_W    = 20,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [VALUE_W-1:0]      load_value,
    input  logic                    mode_dec,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [NUM_DIGITS*7-1:0] seg_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned DIG_W = 4 * NUM_DIGITS;
    localparam int unsigned BCD_W = DIG_W + 4;
    localparam int unsigned PAD_W = (VALUE_W > DIG_W) ? VALUE_W : DIG_W;
    localparam int unsigned CNT_W = $clog2(VALUE_W + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [6:0]  SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned DEC_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] lit_pattern(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] drive(input logic [6:0] lit);
        return ACTIVE_LOW ? ~lit : lit;
    endfunction

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < int'(BCD_W / 4); i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

    state_e                  state_q;
    logic [VALUE_W-1:0]      shift_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        iter_q;
    logic [DIG_W-1:0]        digits_q;
    logic                    digits_valid_q;
    logic                    disp_ovf_q;
    logic                    pend_ovf_q;
    logic                    overflow_q;
    logic                    busy_q;
    logic                    ready_q;
    logic [BLK_W-1:0]        blink_cnt_q;
    logic                    blink_phase_q;
    logic [NUM_DIGITS*7-1:0] seg_q;
    logic [NUM_DIGITS*7-1:0] seg_d;

    logic [PAD_W-1:0] value_pad;
    logic             hex_ovf;
    logic             dec_ovf;
    logic [BCD_W-1:0] bcd_next;
    logic             accept;
    logic             nz_above;
    logic [3:0]       digit;

    assign value_pad = PAD_W'(load_value);
    assign hex_ovf   = |(value_pad >> DIG_W);
    assign dec_ovf   = 64'(load_value) >= DEC_LIMIT;
    assign bcd_next  = dabble_step(bcd_q, shift_q[VALUE_W-1]);
    assign accept    = load_valid && ready_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= StIdle;
            shift_q        <= '0;
            bcd_q          <= '0;
            iter_q         <= '0;
            digits_q       <= '0;
            digits_valid_q <= 1'b0;
            disp_ovf_q     <= 1'b0;
            pend_ovf_q     <= 1'b0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            // Follows the display flag so overflow changes together with seg_out.
            overflow_q <= disp_ovf_q;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (mode_dec) begin
                            state_q    <= StConvert;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b0;
                            shift_q    <= load_value;
                            bcd_q      <= '0;
                            iter_q     <= '0;
                            pend_ovf_q <= dec_ovf;
                        end else begin
                            digits_q       <= value_pad[DIG_W-1:0];
                            disp_ovf_q     <= hex_ovf;
                            digits_valid_q <= 1'b1;
                        end
                    end
                end
                StConvert: begin
                    bcd_q   <= bcd_next;
                    shift_q <= shift_q << 1;
                    iter_q  <= iter_q + 1'b1;
                    if (iter_q == CNT_W'(VALUE_W - 1)) begin
                        digits_q       <= bcd_next[DIG_W-1:0];
                        disp_ovf_q     <= pend_ovf_q;
                        digits_valid_q <= 1'b1;
                        state_q        <= StCommit;
                    end
                end
                StCommit: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    // Walk from the top digit down so nz_above tells whether a nonzero digit sits higher.
    always_comb begin
        seg_d    = '0;
        nz_above = 1'b0;
        digit    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit = digits_q[4*k +: 4];
            if (!digits_valid_q || (blink_en && blink_phase_q)) begin
                seg_d[7*k +: 7] = SEG_OFF;
            end else if (disp_ovf_q) begin
                seg_d[7*k +: 7] = drive(7'h40);
            end else if (blank_lz && (k != 0) && !nz_above && (digit == 4'h0)) begin
                seg_d[7*k +: 7] = SEG_OFF;
            end else begin
                seg_d[7*k +: 7] = drive(lit_pattern(digit));
            end
            nz_above = nz_above | (digit != 4'h0);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            seg_q <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg_out    = seg_q;
    assign load_ready = ready_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_seg7_display_controller.sv
// Scoreboard bench for seg7_display_controller: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_seg7_display_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [19:0] load_value;
    logic        mode_dec;
    logic        blank_lz;
    logic        blink_en;
    logic [41:0] seg_out;
    logic        busy;
    logic        overflow;

    seg7_display_controller #(
        .NUM_DIGITS(6),
        .VALUE_W   (20),
        .ACTIVE_LOW(1'b1),
        .BLINK_DIV (4)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .mode_dec  (mode_dec),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .seg_out   (seg_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          at;
        logic [95:0] name;
        logic [41:0] seg;
        logic        rdy;
        logic        bsy;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    localparam logic [41:0] ALL_OFF = {6{7'h7F}};
    localparam logic [41:0] DASHES  = {6{7'h3F}};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (e.at != cyc) begin
                errors = errors + 1;
                $display("FAIL %s: check slot %0d missed (now %0d)", e.name, e.at, cyc);
            end else if ({seg_out, load_ready, busy, overflow} !== {e.seg, e.rdy, e.bsy, e.ovf}) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: got seg=%h ready=%b busy=%b ovf=%b, want seg=%h ready=%b busy=%b ovf=%b",
                         e.name, cyc, seg_out, load_ready, busy, overflow,
                         e.seg, e.rdy, e.bsy, e.ovf);
            end
        end
    end

    function automatic logic [41:0] mk(input logic [6:0] d5, input logic [6:0] d4,
                                       input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic push(input int at, input logic [95:0] nm, input logic [41:0] s,
                        input logic r, input logic b, input logic o);
        exp_t e;
        e.at = at; e.name = nm; e.seg = s; e.rdy = r; e.bsy = b; e.ovf = o;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [19:0] v, input logic dec);
        load_valid = 1'b1;
        load_value = v;
        mode_dec   = dec;
        step();
        load_valid = 1'b0;
    endtask

    int          t;
    int          r0;
    int          base;
    logic [41:0] v123456;
    logic [41:0] v12345;

    initial begin
        v123456 = mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02);
        v12345  = mk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
        rst_n = 1'b0; load_valid = 1'b0; load_value = '0;
        mode_dec = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        r0 = cyc;
        push(cyc, "rst", ALL_OFF, 1'b1, 1'b0, 1'b0);
        repeat (2) step();
        push(cyc, "rst_idle", ALL_OFF, 1'b1, 1'b0, 1'b0);

        // Decimal 123456: busy through T+20, digits at T+21.
        load(20'd123456, 1'b1);
        t = cyc;
        push(t,      "dec_start", ALL_OFF, 1'b0, 1'b1, 1'b0);
        push(t + 20, "dec_last",  ALL_OFF, 1'b0, 1'b1, 1'b0);
        push(t + 21, "dec_done",  v123456, 1'b1, 1'b0, 1'b0);
        repeat (21) step();

        // Hex 0xA5 with blanking, then blanking removed.
        blank_lz = 1'b1;
        load(20'h000A5, 1'b0);
        t = cyc;
        push(t,     "hex_hold", v123456, 1'b1, 1'b0, 1'b0);
        push(t + 1, "hex_lz",   mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12), 1'b1, 1'b0, 1'b0);
        step();
        blank_lz = 1'b0;
        step();
        push(cyc, "hex_nolz", mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12), 1'b1, 1'b0, 1'b0);

        // Back-to-back hex loads on consecutive edges.
        load_valid = 1'b1; load_value = 20'h00ABC; mode_dec = 1'b0;
        step();
        load_value = 20'hFEDCB;
        step();
        load_valid = 1'b0;
        t = cyc;
        push(t,     "hex_b2b_a", mk(7'h40, 7'h40, 7'h40, 7'h08, 7'h03, 7'h46), 1'b1, 1'b0, 1'b0);
        push(t + 1, "hex_b2b_b", mk(7'h40, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03), 1'b1, 1'b0, 1'b0);
        step();

        // Decimal overflow, then decimal zero with blanking.
        blank_lz = 1'b1;
        load(20'd1000000, 1'b1);
        t = cyc;
        push(t,      "ovf_start", mk(7'h7F, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03), 1'b0, 1'b1, 1'b0);
        push(t + 20, "ovf_last",  mk(7'h7F, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03), 1'b0, 1'b1, 1'b0);
        push(t + 21, "ovf_dash",  DASHES, 1'b1, 1'b0, 1'b1);
        repeat (21) step();
        load(20'd0, 1'b1);
        t = cyc;
        push(t + 20, "zero_last", DASHES, 1'b0, 1'b1, 1'b1);
        push(t + 21, "zero_lz",   mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b1, 1'b0, 1'b0);
        repeat (21) step();

        // Blink: phase after edge r0+j is (j/4)%2; seg at edge E uses the phase after E-1.
        blank_lz = 1'b0;
        load(20'h12345, 1'b0);
        step();
        push(cyc, "hex_12345", v12345, 1'b1, 1'b0, 1'b0);
        blink_en = 1'b1;
        base = cyc;
        for (int e = base + 1; e <= base + 16; e++) begin
            push(e, "blink", ((((e - 1 - r0) / 4) % 2) == 1) ? ALL_OFF : v12345,
                 1'b1, 1'b0, 1'b0);
        end
        repeat (16) step();
        for (int i = 0; i < 8 && (((cyc - r0) / 4) % 2) == 0; i++) step();
        blink_en = 1'b0;
        step();
        push(cyc, "blink_off", v12345, 1'b1, 1'b0, 1'b0);

        // Reset during conversion, with a load attempt while busy.
        load(20'd999999, 1'b1);
        t = cyc;
        step(); step();
        load_valid = 1'b1; load_value = 20'h00001; mode_dec = 1'b0;
        step();
        load_valid = 1'b0;
        push(t + 5, "busy_ign", v12345, 1'b0, 1'b1, 1'b0);
        while (cyc < t + 10) step();
        rst_n = 1'b0;
        push(cyc, "rst_mid", ALL_OFF, 1'b1, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        push(cyc, "rst_after", ALL_OFF, 1'b1, 1'b0, 1'b0);
        repeat (25) step();
        push(cyc, "rst_quiet", ALL_OFF, 1'b1, 1'b0, 1'b0);
        repeat (2) step();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s: never compared (slot %0d)", e.name, e.at);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
